// File: rtl/base_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : base_ram_loader
// Description : Streams bases into a narrow RAM write port. Batches that do
//               not end on a wide-word boundary are padded with zeros; batches
//               longer than the RAM are clipped and the tail is drained.
//               The block holds DONE until the consumer releases the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module base_ram_loader #(
   parameter int WIDTH     = 8,
   parameter int SIZE      = 256,
   parameter int ADDRWIDTH = 8,
   parameter int RATIO     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic                 we,
   output logic [ADDRWIDTH-1:0] addr,
   output logic [WIDTH-1:0]     di,
   output logic                 done,
   output logic [ADDRWIDTH:0]   len,
   output logic                 overflow,
   // "release" is a reserved word in SystemVerilog, hence release_req
   input  logic                 release_req
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_DRAIN = 2'd1,
      S_PAD   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDRWIDTH:0] c_LAST_IDX = (ADDRWIDTH+1)'(SIZE - 1);
   localparam logic [ADDRWIDTH:0] c_SIZE     = (ADDRWIDTH+1)'(SIZE);
   localparam logic [ADDRWIDTH:0] c_MASK     = (ADDRWIDTH+1)'(RATIO - 1);

   state_t               r_state;
   state_t               w_nextState;
   logic [ADDRWIDTH:0]   r_cnt;
   logic [ADDRWIDTH:0]   w_cntInc;
   logic                 w_hs;
   logic                 w_atBoundary;
   logic                 w_wrEn;
   logic [WIDTH-1:0]     w_wrData;
   logic                 w_cntStep;
   logic                 w_setLen;
   logic [ADDRWIDTH:0]   w_lenVal;
   logic                 w_setOvf;
   logic                 w_clrBatch;

   assign in_ready     = ((r_state == S_LOAD) || (r_state == S_DRAIN)) && !reset;
   assign w_hs         = in_valid && in_ready;
   assign w_cntInc     = r_cnt + 1'b1;
   // The count after this write lands on a wide-word boundary
   assign w_atBoundary = ((w_cntInc & c_MASK) == '0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and per-cycle datapath controls
   always_comb begin
      w_nextState = r_state;
      w_wrEn      = 1'b0;
      w_wrData    = '0;
      w_cntStep   = 1'b0;
      w_setLen    = 1'b0;
      w_lenVal    = '0;
      w_setOvf    = 1'b0;
      w_clrBatch  = 1'b0;
      case (r_state)
         S_LOAD: begin
            if (w_hs) begin
               w_wrEn    = 1'b1;
               w_wrData  = in_data;
               w_cntStep = 1'b1;
               if (in_last) begin
                  w_setLen    = 1'b1;
                  w_lenVal    = w_cntInc;
                  w_nextState = w_atBoundary ? S_DONE : S_PAD;
               end else if (r_cnt == c_LAST_IDX) begin
                  // RAM is now full; the rest of the batch is discarded
                  w_setLen    = 1'b1;
                  w_lenVal    = c_SIZE;
                  w_setOvf    = 1'b1;
                  w_nextState = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_hs && in_last) begin
               w_nextState = S_DONE;
            end
         end
         S_PAD: begin
            // PAD is only entered off-boundary, and SIZE is a multiple of
            // RATIO, so the boundary is always reached before the RAM end
            w_wrEn    = 1'b1;
            w_cntStep = 1'b1;
            if (w_atBoundary) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            if (release_req) begin
               w_clrBatch  = 1'b1;
               w_nextState = S_LOAD;
            end
         end
         default: begin
            w_nextState = S_LOAD;
         end
      endcase
   end

   // Registered RAM port, counter and batch status
   always_ff @(posedge clk) begin
      if (reset) begin
         we       <= 1'b0;
         addr     <= '0;
         di       <= '0;
         r_cnt    <= '0;
         len      <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         we <= w_wrEn;
         if (w_wrEn) begin
            addr <= r_cnt[ADDRWIDTH-1:0];
            di   <= w_wrData;
         end
         if (w_clrBatch) begin
            r_cnt <= '0;
         end else if (w_cntStep) begin
            r_cnt <= w_cntInc;
         end
         if (w_setLen) begin
            len <= w_lenVal;
         end
         if (w_clrBatch) begin
            overflow <= 1'b0;
         end else if (w_setOvf) begin
            overflow <= 1'b1;
         end
         // done trails entry into DONE by one cycle so it rises after the
         // final write has been presented to the RAM
         done <= (r_state == S_DONE) && (w_nextState == S_DONE);
      end
   end

endmodule
`default_nettype wire
